// File: rtl/wb_dma_slave_mem_if.sv
// Wishbone B3 bus bundle between the MAC DMA master port and the slave memory.
// Master drives address/data/control; slave returns read data, ack and err.
interface wb_dma_slave_mem_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 32,
   parameter int SEL_W  = 4
);
   logic [ADDR_W-1:0] s_wb_adr_i;
   logic [DATA_W-1:0] s_wb_dat_i;
   logic [DATA_W-1:0] s_wb_dat_o;
   logic [SEL_W-1:0]  s_wb_sel_i;
   logic              s_wb_we_i;
   logic              s_wb_cyc_i;
   logic              s_wb_stb_i;
   logic [2:0]        s_wb_cti_i;
   logic [1:0]        s_wb_bte_i;
   logic              s_wb_ack_o;
   logic              s_wb_err_o;

   modport master (
      output s_wb_adr_i, s_wb_dat_i, s_wb_sel_i, s_wb_we_i, s_wb_cyc_i,
             s_wb_stb_i, s_wb_cti_i, s_wb_bte_i,
      input  s_wb_dat_o, s_wb_ack_o, s_wb_err_o
   );

   modport slave (
      input  s_wb_adr_i, s_wb_dat_i, s_wb_sel_i, s_wb_we_i, s_wb_cyc_i,
             s_wb_stb_i, s_wb_cti_i, s_wb_bte_i,
      output s_wb_dat_o, s_wb_ack_o, s_wb_err_o
   );
endinterface

// File: rtl/wb_dma_slave_mem.sv
// Wishbone B3 slave memory for the MAC DMA port: classic/incr/wrap bursts, wait states, decode errors, backdoor.
// Ack/err registered, first beat W+1 cycles after sampling; optional error injection under WB_SLV_ERR_INJ_EN.
module wb_dma_slave_mem #(
   parameter int                DATA_W    = 32,
   parameter int                ADDR_W    = 32,
   parameter int                SEL_W     = 4,
   parameter int                MEM_DEPTH = 1024,
   parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
   localparam int               IDX_W     = $clog2(MEM_DEPTH)
) (
   input  logic               wb_clk_i,
   input  logic               wb_rst_i,
   wb_dma_slave_mem_if.slave  wb,
   input  logic [2:0]         wait_cfg_i,
   input  logic               bd_we_i,
   input  logic [IDX_W-1:0]   bd_adr_i,
   input  logic [DATA_W-1:0]  bd_dat_i,
   output logic [DATA_W-1:0]  bd_dat_o,
`ifdef WB_SLV_ERR_INJ_EN
   input  logic               err_inj_i,
   input  logic [IDX_W-1:0]   err_inj_adr_i,
`endif
   output logic [15:0]        beat_cnt_o,
   output logic [7:0]         err_cnt_o
);

   typedef enum logic [1:0] {IDLE, WAIT, ACK, ERR} state_t;

   localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(MEM_DEPTH);

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] idx_q, idx_d;
   logic [2:0]        cnt_q, cnt_d;
   logic              ack_q, ack_d;
   logic              err_q, err_d;
   logic [DATA_W-1:0] dat_q, dat_d;
   logic [15:0]       beat_cnt_q, beat_cnt_d;
   logic [7:0]        err_cnt_q, err_cnt_d;
   logic              wr_en;

   logic [DATA_W-1:0] mem_q [MEM_DEPTH];

   logic              bus_act;
   logic [ADDR_W-1:0] adr_idx;
   logic              dec_err;
   logic [ADDR_W-1:0] idx_nxt;
   logic              inj_en;
   logic [ADDR_W-1:0] inj_adr;

`ifdef WB_SLV_ERR_INJ_EN
   assign inj_en  = err_inj_i;
   assign inj_adr = ADDR_W'(err_inj_adr_i);
`else
   assign inj_en  = 1'b0;
   assign inj_adr = '0;
`endif

   assign bus_act = wb.s_wb_cyc_i & wb.s_wb_stb_i;
   assign adr_idx = (wb.s_wb_adr_i - BASE_ADDR) >> 2;
   assign dec_err = (wb.s_wb_adr_i[1:0] != 2'b00) || (wb.s_wb_adr_i < BASE_ADDR) ||
                    (adr_idx >= DEPTH_A);

   // Wrap bursts only advance the low index bits, keeping the aligned block fixed.
   always_comb begin
      case (wb.s_wb_bte_i)
         2'b01:   idx_nxt = {idx_q[ADDR_W-1:2], idx_q[1:0] + 2'd1};
         2'b10:   idx_nxt = {idx_q[ADDR_W-1:3], idx_q[2:0] + 3'd1};
         2'b11:   idx_nxt = {idx_q[ADDR_W-1:4], idx_q[3:0] + 4'd1};
         default: idx_nxt = idx_q + 1'b1;
      endcase
   end

   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      cnt_d      = cnt_q;
      ack_d      = 1'b0;
      err_d      = 1'b0;
      dat_d      = '0;
      beat_cnt_d = beat_cnt_q;
      err_cnt_d  = err_cnt_q;
      wr_en      = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus_act) begin
               idx_d = adr_idx;
               if (dec_err || (wait_cfg_i == 3'd0 && inj_en && adr_idx == inj_adr)) begin
                  state_d = ERR;
                  err_d   = 1'b1;
               end else if (wait_cfg_i == 3'd0) begin
                  state_d = ACK;
                  ack_d   = 1'b1;
               end else begin
                  state_d = WAIT;
                  cnt_d   = wait_cfg_i;
               end
            end
         end
         WAIT: begin
            if (!wb.s_wb_cyc_i) begin
               state_d = IDLE;
            end else if (cnt_q == 3'd1) begin
               if (inj_en && idx_q == inj_adr) begin
                  state_d = ERR;
                  err_d   = 1'b1;
               end else begin
                  state_d = ACK;
                  ack_d   = 1'b1;
               end
            end else begin
               cnt_d = cnt_q - 3'd1;
            end
         end
         ACK: begin
            state_d = IDLE;
            if (bus_act) begin
               wr_en      = wb.s_wb_we_i;
               beat_cnt_d = (beat_cnt_q == 16'hFFFF) ? beat_cnt_q : beat_cnt_q + 16'd1;
               if (wb.s_wb_cti_i == 3'b010) begin
                  idx_d = idx_nxt;
                  if (idx_nxt >= DEPTH_A || (inj_en && idx_nxt == inj_adr)) begin
                     state_d = ERR;
                     err_d   = 1'b1;
                  end else begin
                     state_d = ACK;
                     ack_d   = 1'b1;
                  end
               end
            end
         end
         ERR: begin
            state_d   = IDLE;
            err_cnt_d = (err_cnt_q == 8'hFF) ? err_cnt_q : err_cnt_q + 8'd1;
         end
         default: state_d = IDLE;
      endcase
      if (ack_d) dat_d = mem_q[idx_d[IDX_W-1:0]];
   end

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         state_q    <= IDLE;
         idx_q      <= '0;
         cnt_q      <= '0;
         ack_q      <= 1'b0;
         err_q      <= 1'b0;
         dat_q      <= '0;
         beat_cnt_q <= '0;
         err_cnt_q  <= '0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         cnt_q      <= cnt_d;
         ack_q      <= ack_d;
         err_q      <= err_d;
         dat_q      <= dat_d;
         beat_cnt_q <= beat_cnt_d;
         err_cnt_q  <= err_cnt_d;
      end
   end

   // Storage survives reset; the later backdoor assignment overrides a same-word bus write.
   always_ff @(posedge wb_clk_i) begin
      if (wr_en) begin
         for (int b = 0; b < SEL_W; b++) begin
            if (wb.s_wb_sel_i[b]) mem_q[idx_q[IDX_W-1:0]][8*b +: 8] <= wb.s_wb_dat_i[8*b +: 8];
         end
      end
      if (bd_we_i) mem_q[bd_adr_i] <= bd_dat_i;
   end

   assign bd_dat_o      = mem_q[bd_adr_i];
   assign wb.s_wb_ack_o = ack_q;
   assign wb.s_wb_err_o = err_q;
   assign wb.s_wb_dat_o = dat_q;
   assign beat_cnt_o    = beat_cnt_q;
   assign err_cnt_o     = err_cnt_q;

endmodule

// File: tb/tb_wb_dma_slave_mem.sv
// Directed bench for wb_dma_slave_mem; cycle 0 is the cycle in which a transfer is first driven.
module tb_wb_dma_slave_mem;
   logic        clk;
   logic        rst;
   logic [2:0]  wait_cfg;
   logic        bd_we;
   logic [9:0]  bd_adr;
   logic [31:0] bd_wdat;
   logic [31:0] bd_rdat;
   logic [15:0] beat_cnt;
   logic [7:0]  err_cnt;
`ifdef WB_SLV_ERR_INJ_EN
   logic        err_inj;
   logic [9:0]  err_inj_adr;
`endif
   int          tests;
   int          fails;

   wb_dma_slave_mem_if #(.DATA_W(32), .ADDR_W(32), .SEL_W(4)) wb ();

   wb_dma_slave_mem #(
      .DATA_W(32), .ADDR_W(32), .SEL_W(4), .MEM_DEPTH(1024), .BASE_ADDR(32'h0000_0000)
   ) dut (
      .wb_clk_i      (clk),
      .wb_rst_i      (rst),
      .wb            (wb),
      .wait_cfg_i    (wait_cfg),
      .bd_we_i       (bd_we),
      .bd_adr_i      (bd_adr),
      .bd_dat_i      (bd_wdat),
      .bd_dat_o      (bd_rdat),
`ifdef WB_SLV_ERR_INJ_EN
      .err_inj_i     (err_inj),
      .err_inj_adr_i (err_inj_adr),
`endif
      .beat_cnt_o    (beat_cnt),
      .err_cnt_o     (err_cnt)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic bus_idle();
      wb.s_wb_cyc_i = 1'b0;
      wb.s_wb_stb_i = 1'b0;
      wb.s_wb_we_i  = 1'b0;
      wb.s_wb_adr_i = '0;
      wb.s_wb_dat_i = '0;
      wb.s_wb_sel_i = '0;
      wb.s_wb_cti_i = 3'b000;
      wb.s_wb_bte_i = 2'b00;
   endtask

   task automatic drive(input logic [31:0] adr, input logic [31:0] dat, input logic we,
                        input logic [3:0] sel, input logic [2:0] cti, input logic [1:0] bte);
      wb.s_wb_cyc_i = 1'b1;
      wb.s_wb_stb_i = 1'b1;
      wb.s_wb_adr_i = adr;
      wb.s_wb_dat_i = dat;
      wb.s_wb_we_i  = we;
      wb.s_wb_sel_i = sel;
      wb.s_wb_cti_i = cti;
      wb.s_wb_bte_i = bte;
   endtask

   task automatic bd_write(input logic [9:0] idx, input logic [31:0] d);
      bd_we   = 1'b1;
      bd_adr  = idx;
      bd_wdat = d;
      step();
      bd_we   = 1'b0;
   endtask

   task automatic bd_read(input logic [9:0] idx, output logic [31:0] d);
      bd_adr = idx;
      #1;
      d = bd_rdat;
   endtask

   // Bounded wait for the first ack or err; n is the cycle it appeared in.
   task automatic wait_resp(output int n, output logic got_ack, output logic got_err,
                            output logic [31:0] rd);
      n = 0; got_ack = 1'b0; got_err = 1'b0; rd = '0;
      while (!got_ack && !got_err && n < 20) begin
         step();
         n++;
         got_ack = wb.s_wb_ack_o;
         got_err = wb.s_wb_err_o;
         rd      = wb.s_wb_dat_o;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus_idle();
      step();
      step();
      tests++; if (wb.s_wb_ack_o !== 1'b0) begin fails++; $display("FAIL reset_ack got %b want 0", wb.s_wb_ack_o); end
      tests++; if (wb.s_wb_err_o !== 1'b0) begin fails++; $display("FAIL reset_err got %b want 0", wb.s_wb_err_o); end
      tests++; if (wb.s_wb_dat_o !== 32'h0) begin fails++; $display("FAIL reset_dat got %h want 0", wb.s_wb_dat_o); end
      tests++; if (beat_cnt !== 16'd0) begin fails++; $display("FAIL reset_beat_cnt got %0d want 0", beat_cnt); end
      tests++; if (err_cnt !== 8'd0) begin fails++; $display("FAIL reset_err_cnt got %0d want 0", err_cnt); end
      rst = 1'b0;
      step();
   endtask

   task automatic test_classic_read();
      int n; logic a, e; logic [31:0] rd;
      bd_write(10'd5, 32'hA5A5_0001);
      wait_cfg = 3'd0;
      drive(32'h14, 32'h0, 1'b0, 4'hF, 3'b000, 2'b00);
      wait_resp(n, a, e, rd);
      tests++; if (a !== 1'b1 || n != 1) begin fails++; $display("FAIL rd_ack_cycle got ack=%b cycle=%0d want ack=1 cycle=1", a, n); end
      tests++; if (rd !== 32'hA5A5_0001) begin fails++; $display("FAIL rd_data got %h want a5a50001", rd); end
      step();
      bus_idle();
      tests++; if (wb.s_wb_ack_o !== 1'b0) begin fails++; $display("FAIL rd_single_ack got %b want 0", wb.s_wb_ack_o); end
      tests++; if (beat_cnt !== 16'd1) begin fails++; $display("FAIL rd_beat_cnt got %0d want 1", beat_cnt); end
   endtask

   task automatic test_classic_write();
      int n; logic a, e; logic [31:0] rd, m;
      bd_write(10'd8, 32'h0);
      wait_cfg = 3'd3;
      drive(32'h20, 32'h1122_3344, 1'b1, 4'b0101, 3'b000, 2'b00);
      step();
      wait_cfg = 3'd0;
      wait_resp(n, a, e, rd);
      tests++; if (a !== 1'b1 || n + 1 != 4) begin fails++; $display("FAIL wr_ack_cycle got ack=%b cycle=%0d want ack=1 cycle=4", a, n + 1); end
      step();
      bus_idle();
      bd_read(10'd8, m);
      tests++; if (m !== 32'h0022_0044) begin fails++; $display("FAIL wr_byte_sel got %h want 00220044", m); end
      tests++; if (beat_cnt !== 16'd2) begin fails++; $display("FAIL wr_beat_cnt got %0d want 2", beat_cnt); end
   endtask

   task automatic test_wrap_burst();
      int n; logic a, e; logic [31:0] rd, m;
      logic [31:0] adrs [4];
      logic [31:0] dats [4];
      logic [9:0]  idxs [4];
      adrs = '{32'h38, 32'h3C, 32'h30, 32'h34};
      dats = '{32'hB000_0000, 32'hB111_1111, 32'hB222_2222, 32'hB333_3333};
      idxs = '{10'd14, 10'd15, 10'd12, 10'd13};
      wait_cfg = 3'd2;
      drive(adrs[0], dats[0], 1'b1, 4'hF, 3'b010, 2'b01);
      wait_resp(n, a, e, rd);
      tests++; if (a !== 1'b1 || n != 3) begin fails++; $display("FAIL wrap_first got ack=%b cycle=%0d want ack=1 cycle=3", a, n); end
      for (int k = 1; k < 4; k++) begin
         step();
         drive(adrs[k], dats[k], 1'b1, 4'hF, (k == 3) ? 3'b111 : 3'b010, 2'b01);
         tests++; if (wb.s_wb_ack_o !== 1'b1) begin fails++; $display("FAIL wrap_beat%0d got ack=%b want 1 in cycle %0d", k, wb.s_wb_ack_o, 3 + k); end
      end
      step();
      tests++; if (wb.s_wb_ack_o !== 1'b0) begin fails++; $display("FAIL wrap_end got ack=%b want 0", wb.s_wb_ack_o); end
      bus_idle();
      for (int k = 0; k < 4; k++) begin
         bd_read(idxs[k], m);
         tests++; if (m !== dats[k]) begin fails++; $display("FAIL wrap_mem idx %0d got %h want %h", idxs[k], m, dats[k]); end
      end
      tests++; if (beat_cnt !== 16'd6) begin fails++; $display("FAIL wrap_beat_cnt got %0d want 6", beat_cnt); end
   endtask

   task automatic test_back_to_back();
      int n; logic a, e; logic [31:0] rd;
      wait_cfg = 3'd1;
      drive(32'h14, 32'h0, 1'b0, 4'hF, 3'b000, 2'b00);
      wait_resp(n, a, e, rd);
      tests++; if (a !== 1'b1 || n != 2 || rd !== 32'hA5A5_0001) begin fails++; $display("FAIL b2b_first got ack=%b cycle=%0d dat=%h want 1/2/a5a50001", a, n, rd); end
      step();
      tests++; if (wb.s_wb_ack_o !== 1'b0) begin fails++; $display("FAIL b2b_idle_gap got ack=%b want 0", wb.s_wb_ack_o); end
      wb.s_wb_adr_i = 32'h20;
      wait_resp(n, a, e, rd);
      tests++; if (a !== 1'b1 || n != 2 || rd !== 32'h0022_0044) begin fails++; $display("FAIL b2b_second got ack=%b cycle=%0d dat=%h want 1/2/00220044", a, n, rd); end
      step();
      bus_idle();
      tests++; if (beat_cnt !== 16'd8) begin fails++; $display("FAIL b2b_beat_cnt got %0d want 8", beat_cnt); end
   endtask

   task automatic test_decode_err();
      int n; logic a, e; logic [31:0] rd, m;
      bd_write(10'd0, 32'hDEAD_BEEF);
      wait_cfg = 3'd0;
      drive(32'h1002, 32'h0, 1'b1, 4'hF, 3'b000, 2'b00);
      wait_resp(n, a, e, rd);
      tests++; if (e !== 1'b1 || a !== 1'b0 || n != 1) begin fails++; $display("FAIL misalign_err got err=%b ack=%b cycle=%0d want 1/0/1", e, a, n); end
      tests++; if (rd !== 32'h0) begin fails++; $display("FAIL err_dat got %h want 0", rd); end
      bus_idle();
      step();
      tests++; if (wb.s_wb_err_o !== 1'b0 || err_cnt !== 8'd1) begin fails++; $display("FAIL misalign_after got err=%b cnt=%0d want 0/1", wb.s_wb_err_o, err_cnt); end
      drive(32'h1000, 32'h0, 1'b1, 4'hF, 3'b000, 2'b00);
      wait_resp(n, a, e, rd);
      tests++; if (e !== 1'b1 || a !== 1'b0 || n != 1) begin fails++; $display("FAIL range_err got err=%b ack=%b cycle=%0d want 1/0/1", e, a, n); end
      bus_idle();
      step();
      tests++; if (err_cnt !== 8'd2) begin fails++; $display("FAIL range_err_cnt got %0d want 2", err_cnt); end
      bd_read(10'd0, m);
      tests++; if (m !== 32'hDEAD_BEEF) begin fails++; $display("FAIL err_no_write got %h want deadbeef", m); end
      tests++; if (beat_cnt !== 16'd8) begin fails++; $display("FAIL err_beat_cnt got %0d want 8", beat_cnt); end
   endtask

   task automatic test_burst_end();
      int n; logic a, e; logic [31:0] rd;
      bd_write(10'd1023, 32'h0BAD_F00D);
      wait_cfg = 3'd0;
      drive(32'hFFC, 32'h0, 1'b0, 4'hF, 3'b010, 2'b00);
      wait_resp(n, a, e, rd);
      tests++; if (a !== 1'b1 || n != 1 || rd !== 32'h0BAD_F00D) begin fails++; $display("FAIL top_word got ack=%b cycle=%0d dat=%h want 1/1/0badf00d", a, n, rd); end
      step();
      drive(32'h1000, 32'h0, 1'b0, 4'hF, 3'b010, 2'b00);
      tests++; if (wb.s_wb_err_o !== 1'b1 || wb.s_wb_ack_o !== 1'b0) begin fails++; $display("FAIL burst_overrun got err=%b ack=%b want 1/0", wb.s_wb_err_o, wb.s_wb_ack_o); end
      bus_idle();
      step();
      tests++; if (wb.s_wb_err_o !== 1'b0 || wb.s_wb_ack_o !== 1'b0) begin fails++; $display("FAIL overrun_end got err=%b ack=%b want 0/0", wb.s_wb_err_o, wb.s_wb_ack_o); end
      tests++; if (err_cnt !== 8'd3 || beat_cnt !== 16'd9) begin fails++; $display("FAIL overrun_cnts got err=%0d beats=%0d want 3/9", err_cnt, beat_cnt); end
   endtask

   task automatic test_cyc_drop_and_reset();
      int n; logic a, e; logic [31:0] rd, m;
      bd_write(10'd2, 32'h0);
      bd_write(10'd3, 32'h0);
      bd_write(10'd4, 32'h0);
      wait_cfg = 3'd0;
      drive(32'h8, 32'hC0DE_0002, 1'b1, 4'hF, 3'b010, 2'b00);
      wait_resp(n, a, e, rd);
      tests++; if (a !== 1'b1 || n != 1) begin fails++; $display("FAIL drop_beat0 got ack=%b cycle=%0d want 1/1", a, n); end
      step();
      drive(32'hC, 32'hC0DE_0003, 1'b1, 4'hF, 3'b010, 2'b00);
      tests++; if (wb.s_wb_ack_o !== 1'b1) begin fails++; $display("FAIL drop_beat1 got ack=%b want 1", wb.s_wb_ack_o); end
      step();
      bus_idle();
      step();
      tests++; if (wb.s_wb_ack_o !== 1'b0) begin fails++; $display("FAIL drop_idle got ack=%b want 0", wb.s_wb_ack_o); end
      bd_read(10'd2, m);
      tests++; if (m !== 32'hC0DE_0002) begin fails++; $display("FAIL drop_idx2 got %h want c0de0002", m); end
      bd_read(10'd3, m);
      tests++; if (m !== 32'hC0DE_0003) begin fails++; $display("FAIL drop_idx3 got %h want c0de0003", m); end
      bd_read(10'd4, m);
      tests++; if (m !== 32'h0) begin fails++; $display("FAIL drop_idx4 got %h want 0", m); end
      tests++; if (beat_cnt !== 16'd11) begin fails++; $display("FAIL drop_beat_cnt got %0d want 11", beat_cnt); end
      drive(32'h8, 32'h0, 1'b0, 4'hF, 3'b010, 2'b00);
      wait_resp(n, a, e, rd);
      step();
      drive(32'hC, 32'h0, 1'b0, 4'hF, 3'b010, 2'b00);
      tests++; if (wb.s_wb_ack_o !== 1'b1) begin fails++; $display("FAIL rst_pre_ack got ack=%b want 1", wb.s_wb_ack_o); end
      rst = 1'b1;
      #1;
      tests++; if (wb.s_wb_ack_o !== 1'b0 || wb.s_wb_dat_o !== 32'h0) begin fails++; $display("FAIL rst_async got ack=%b dat=%h want 0/0", wb.s_wb_ack_o, wb.s_wb_dat_o); end
      tests++; if (beat_cnt !== 16'd0 || err_cnt !== 8'd0) begin fails++; $display("FAIL rst_cnts got beats=%0d errs=%0d want 0/0", beat_cnt, err_cnt); end
      bus_idle();
      step();
      rst = 1'b0;
      step();
      drive(32'h8, 32'h0, 1'b0, 4'hF, 3'b000, 2'b00);
      wait_resp(n, a, e, rd);
      tests++; if (a !== 1'b1 || n != 1 || rd !== 32'hC0DE_0002) begin fails++; $display("FAIL rst_idle_read got ack=%b cycle=%0d dat=%h want 1/1/c0de0002", a, n, rd); end
      step();
      bus_idle();
   endtask

`ifdef WB_SLV_ERR_INJ_EN
   task automatic test_err_inj();
      int n; logic a, e; logic [31:0] rd;
      err_inj_adr = 10'd3;
      err_inj     = 1'b1;
      wait_cfg    = 3'd0;
      drive(32'h4, 32'h0, 1'b0, 4'hF, 3'b010, 2'b00);
      wait_resp(n, a, e, rd);
      tests++; if (a !== 1'b1 || n != 1) begin fails++; $display("FAIL inj_idx1 got ack=%b cycle=%0d want 1/1", a, n); end
      step();
      drive(32'h8, 32'h0, 1'b0, 4'hF, 3'b010, 2'b00);
      tests++; if (wb.s_wb_ack_o !== 1'b1 || wb.s_wb_dat_o !== 32'hC0DE_0002) begin fails++; $display("FAIL inj_idx2 got ack=%b dat=%h want 1/c0de0002", wb.s_wb_ack_o, wb.s_wb_dat_o); end
      step();
      drive(32'hC, 32'h0, 1'b0, 4'hF, 3'b010, 2'b00);
      tests++; if (wb.s_wb_err_o !== 1'b1 || wb.s_wb_ack_o !== 1'b0) begin fails++; $display("FAIL inj_idx3 got err=%b ack=%b want 1/0", wb.s_wb_err_o, wb.s_wb_ack_o); end
      bus_idle();
      step();
      tests++; if (wb.s_wb_ack_o !== 1'b0 || wb.s_wb_err_o !== 1'b0) begin fails++; $display("FAIL inj_end got ack=%b err=%b want 0/0", wb.s_wb_ack_o, wb.s_wb_err_o); end
      tests++; if (err_cnt !== 8'd1 || beat_cnt !== 16'd3) begin fails++; $display("FAIL inj_cnts got errs=%0d beats=%0d want 1/3", err_cnt, beat_cnt); end
      err_inj = 1'b0;
   endtask
`endif

   initial begin
      tests    = 0;
      fails    = 0;
      rst      = 1'b1;
      wait_cfg = 3'd0;
      bd_we    = 1'b0;
      bd_adr   = '0;
      bd_wdat  = '0;
`ifdef WB_SLV_ERR_INJ_EN
      err_inj     = 1'b0;
      err_inj_adr = '0;
`endif
      test_reset();
      test_classic_read();
      test_classic_write();
      test_wrap_burst();
      test_back_to_back();
      test_decode_err();
      test_burst_end();
      test_cyc_drop_and_reset();
`ifdef WB_SLV_ERR_INJ_EN
      test_err_inj();
`endif
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
